// File: rtl/fifo_rd_stream.sv
// Streams words out of a registered-read FIFO onto a valid/ready interface.
// Keeps a 2-entry skid buffer so a 1-cycle read latency still allows full throughput.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic [DATA_WIDTH-1:0] skid_q [2];
  logic                  head_q;
  logic                  tail_q;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  pop;
  logic [2:0]            level;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = skid_q[head_q];
  assign pop      = m_valid & m_ready;
  assign xfer_cnt = cnt_q;

  // Words already owned (buffered + inflight) after this cycle's pop; one slot must stay free.
  assign level      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign fifo_rd_en = rst_ & en & ~fifo_empty & (level <= 3'd1);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (inflight_q) tail_q <= ~tail_q;
      if (pop) begin
        head_q <= ~head_q;
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
      end
      case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Data storage carries no reset; m_valid qualifies it.
  always_ff @(posedge clk) begin
    if (inflight_q) skid_q[tail_q] <= fifo_dout;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and random stimulus for fifo_rd_stream with a registered-read FIFO model
// and an in-order word scoreboard driven by the read/accept rules.
module tb_fifo_rd_stream;

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned MEMD = 1024;

  logic          clk;
  logic          rst_;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] xfer_cnt;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .xfer_cnt   (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model storage
  logic [DW-1:0] mem [MEMD];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  // Reference model: words owned by the block and the expected output order
  logic [DW-1:0] exp_q [$];
  int outstanding = 0;
  int infl_m      = 0;
  int exp_cnt     = 0;

  int vectors   = 0;
  int miscmp    = 0;
  int rd_act    = 0;
  int beat_act  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr % MEMD] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clr_counts();
    rd_act   = 0;
    beat_act = 0;
  endtask

  // Called at a falling edge; applies inputs, checks one cycle, returns at the next falling edge.
  task automatic step(input logic e, input logic r);
    int   occ_m;
    logic ev, ep, er, rd_s;
    en = e;
    m_ready = r;
    #1;
    occ_m = outstanding - infl_m;
    ev = (occ_m != 0);
    ep = ev && r;
    er = e && (wr_ptr != rd_ptr) && ((outstanding - int'(ep)) <= 1);
    chk("rd_en", 32'(fifo_rd_en), 32'(er));
    chk("m_valid", 32'(m_valid), 32'(ev));
    if (ev && exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    if (fifo_rd_en) rd_act++;
    if (m_valid && m_ready) beat_act++;
    rd_s = fifo_rd_en;
    @(posedge clk);
    if (rd_s) begin
      fifo_dout <= mem[rd_ptr % MEMD];
      rd_ptr    <= rd_ptr + 1;
    end
    if (er) exp_q.push_back(mem[rd_ptr % MEMD]);
    if (ep) begin
      void'(exp_q.pop_front());
      exp_cnt = (exp_cnt + 1) % 16;
    end
    outstanding = outstanding + int'(er) - int'(ep);
    infl_m = int'(er);
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge, checks the immediate effect, releases one cycle later.
  task automatic do_reset();
    rst_ = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rd_ptr = wr_ptr;
    exp_q.delete();
    outstanding = 0;
    infl_m = 0;
    exp_cnt = 0;
    @(negedge clk);
    chk("rst_hold_valid", 32'(m_valid), 32'd0);
    rst_ = 1'b1;
  endtask

  initial begin
    rst_ = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    fifo_dout = '0;
    @(negedge clk);

    // Three preloaded words at full rate
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    do_reset();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    clr_counts();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    chk("s1_rd_pulses", 32'(rd_act), 32'd3);
    chk("s1_beats", 32'(beat_act), 32'd3);
    chk("s1_cnt", 32'(xfer_cnt), 32'd3);

    // Backpressure: buffer fills, data held, then drains in order
    do_reset();
    push_word(8'hA0); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    clr_counts();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("s2_rd_while_full", 32'(rd_act), 32'd2);
    chk("s2_held_data", 32'(m_data), 32'hA0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("s2_rd_pulses", 32'(rd_act), 32'd4);
    chk("s2_beats", 32'(beat_act), 32'd4);

    // Empty FIFO, then a single write
    do_reset();
    clr_counts();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    chk("s3_empty_rd", 32'(rd_act), 32'd0);
    push_word(8'h5C);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("s3_rd_pulses", 32'(rd_act), 32'd1);
    chk("s3_beats", 32'(beat_act), 32'd1);

    // en dropped right after a read: the word still arrives, no further reads
    do_reset();
    push_word(8'h71); push_word(8'h72);
    clr_counts();
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("s4_rd_pulses", 32'(rd_act), 32'd1);
    chk("s4_beats", 32'(beat_act), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    chk("s4_drain_beats", 32'(beat_act), 32'd2);

    // Reset with a full buffer: nothing stale afterwards
    do_reset();
    push_word(8'h91); push_word(8'h92); push_word(8'h93);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    do_reset();
    clr_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("s5_no_stale", 32'(beat_act), 32'd0);

    // Counter wrap over 17 beats
    do_reset();
    for (int i = 0; i < 17; i++) push_word(8'(i + 8'h40));
    clr_counts();
    for (int i = 0; i < 21; i++) step(1'b1, 1'b1);
    chk("s6_beats", 32'(beat_act), 32'd17);
    chk("s6_cnt_wrap", 32'(xfer_cnt), 32'd1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1) push_word(8'($urandom));
      step(($urandom_range(9, 0) < 8) ? 1'b1 : 1'b0, ($urandom_range(9, 0) < 6) ? 1'b1 : 1'b0);
      if (i == 200) do_reset();
    end
    for (int i = 0; i < 600 && (wr_ptr != rd_ptr || exp_q.size() != 0); i++) step(1'b1, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
